// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter
//
// Round-robin arbiter that lets four requesters share one serial port's
// transmit path. For each granted byte it polls the port's status register
// until the tx FIFO reports not-full, writes the byte to the data register,
// pulses ack to the winner, then idles two cycles so the port's full flag
// can settle before the next poll.
//
// Parameters
//   DEVADDR        base address of the port; data reg at +0, status reg at +1
//   TIMEOUT_POLLS  full-status polls tolerated before the request is aborted
//
// Ports
//   cpu_clk        sole clock, rising edge
//   reset          asynchronous, active-high
//   req[3:0]       per-requester level request
//   req_data[31:0] byte i on bits [8i+7:8i]
//   ack[3:0]       one-cycle pulse when requester i's byte has been written
//   timeout_err    one-cycle pulse when requester i's request is aborted
//   outbus_*       write bus to the port
//   inbus_*        read bus; read data is valid the cycle after inbus_re
//
// Configuration
//   RS232_ARB_TIMEOUT_EN  when defined, adds the poll counter and the abort
//                         path; otherwise polling continues indefinitely and
//                         timeout_err is held at zero.

module rs232_tx_arbiter #(
    parameter logic [7:0] DEVADDR       = 8'h00,
    parameter logic [7:0] TIMEOUT_POLLS = 8'd255
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic [3:0]  timeout_err,
    output logic [7:0]  outbus_addr,
    output logic [7:0]  outbus_data,
    output logic        outbus_we,
    output logic [7:0]  inbus_addr,
    output logic        inbus_re,
    input  logic [7:0]  inbus_data
);

    localparam logic [5:0] S_IDLE     = 6'b00_0001;
    localparam logic [5:0] S_STAT_RD  = 6'b00_0010;
    localparam logic [5:0] S_STAT_CHK = 6'b00_0100;
    localparam logic [5:0] S_WRITE    = 6'b00_1000;
    localparam logic [5:0] S_ACK      = 6'b01_0000;
    localparam logic [5:0] S_GAP      = 6'b10_0000;

    logic [5:0] state_q, state_d;
    logic [1:0] winner_q, winner_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] byte_q, byte_d;
    logic       gap_q, gap_d;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       req_held;
    logic       tx_full;
    logic       poll_timeout;
    logic       poll_inc;
    logic       poll_clr;
    logic       timeout_fire;

    assign req_held = req[winner_q];
    assign tx_full  = inbus_data[1];

    // Only the tx-full flag of the status register matters here.
    logic unused_status_bits;
    assign unused_status_bits = ^{inbus_data[7:2], inbus_data[0]};

    // Round-robin pick: scan from rr_ptr upward; iterating from the farthest
    // offset down leaves the closest set bit as the final assignment.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = rr_ptr_q + 2'(i);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state logic. A withdrawn request abandons the transfer only before
    // WRITE; once the byte is on the bus the ack always follows.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        rr_ptr_d     = rr_ptr_q;
        byte_d       = byte_q;
        gap_d        = gap_q;
        poll_inc     = 1'b0;
        poll_clr     = 1'b0;
        timeout_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    winner_d = pick_idx;
                    byte_d   = req_data[{pick_idx, 3'b000} +: 8];
                    state_d  = S_STAT_RD;
                end
            end
            S_STAT_RD: begin
                if (!req_held) begin
                    state_d  = S_IDLE;
                    poll_clr = 1'b1;
                end else begin
                    state_d = S_STAT_CHK;
                end
            end
            S_STAT_CHK: begin
                if (!req_held) begin
                    state_d  = S_IDLE;
                    poll_clr = 1'b1;
                end else if (tx_full && poll_timeout) begin
                    state_d      = S_GAP;
                    gap_d        = 1'b0;
                    rr_ptr_d     = winner_q + 2'd1;
                    timeout_fire = 1'b1;
                    poll_clr     = 1'b1;
                end else if (tx_full) begin
                    state_d  = S_STAT_RD;
                    poll_inc = 1'b1;
                end else begin
                    state_d  = S_WRITE;
                    poll_clr = 1'b1;
                end
            end
            S_WRITE: begin
                state_d = S_ACK;
            end
            S_ACK: begin
                rr_ptr_d = winner_q + 2'd1;
                gap_d    = 1'b0;
                state_d  = S_GAP;
            end
            S_GAP: begin
                if (gap_q) begin
                    gap_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            winner_q <= 2'd0;
            rr_ptr_q <= 2'd0;
            byte_q   <= 8'h00;
            gap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            rr_ptr_q <= rr_ptr_d;
            byte_q   <= byte_d;
            gap_q    <= gap_d;
        end
    end

`ifdef RS232_ARB_TIMEOUT_EN
    logic [7:0] poll_cnt_q, poll_cnt_d;
    logic [3:0] timeout_err_q, timeout_err_d;

    // Compared in 9 bits so the increment cannot wrap past the limit.
    assign poll_timeout = ({1'b0, poll_cnt_q} + 9'd1) >= {1'b0, TIMEOUT_POLLS};
    assign timeout_err  = timeout_err_q;

    always_comb begin
        poll_cnt_d = poll_cnt_q;
        if (poll_clr) begin
            poll_cnt_d = 8'd0;
        end else if (poll_inc) begin
            poll_cnt_d = poll_cnt_q + 8'd1;
        end
        timeout_err_d = timeout_fire ? (4'b0001 << winner_q) : 4'b0000;
    end

    // The error pulse is registered, so it lands in the first GAP cycle.
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            poll_cnt_q    <= 8'd0;
            timeout_err_q <= 4'b0000;
        end else begin
            poll_cnt_q    <= poll_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`else
    assign poll_timeout = 1'b0;
    assign timeout_err  = 4'b0000;

    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_POLLS, poll_inc, poll_clr, timeout_fire};
`endif

    // Bus outputs decode straight from the state flops, so an asynchronous
    // reset silences the buses in the same cycle it is asserted.
    always_comb begin
        outbus_we   = 1'b0;
        outbus_addr = 8'h00;
        outbus_data = 8'h00;
        inbus_re    = 1'b0;
        inbus_addr  = 8'h00;
        ack         = 4'b0000;
        case (state_q)
            S_STAT_RD: begin
                inbus_re   = 1'b1;
                inbus_addr = DEVADDR + 8'd1;
            end
            S_WRITE: begin
                outbus_we   = 1'b1;
                outbus_addr = DEVADDR;
                outbus_data = byte_q;
            end
            S_ACK: begin
                ack = 4'b0001 << winner_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// tb_rs232_tx_arbiter
//
// Self-checking bench for rs232_tx_arbiter. A small port model answers
// status reads (full for a programmed number of polls, then not-full); a
// scoreboard queue holds the expected writes and acks, which a negedge
// monitor pops and compares. Build with RS232_ARB_TIMEOUT_EN defined to
// exercise the abort path.

module tb_rs232_tx_arbiter;

    localparam logic [7:0] DEV = 8'h40;
`ifdef RS232_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_POLLS     = 8'd3;
    localparam int         V4_POLLS     = 2;
    localparam int         WD_POLLS     = 1;
    localparam int         EXP_TIMEOUTS = 1;
`else
    localparam logic [7:0] TO_POLLS     = 8'd255;
    localparam int         V4_POLLS     = 5;
    localparam int         WD_POLLS     = 10;
    localparam int         EXP_TIMEOUTS = 0;
`endif

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  timeout_err;
    logic [7:0]  outbus_addr;
    logic [7:0]  outbus_data;
    logic        outbus_we;
    logic [7:0]  inbus_addr;
    logic        inbus_re;
    logic [7:0]  inbus_data = 8'h00;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          polls;
        logic [3:0]  exp_ack;
        logic [7:0]  exp_byte;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] mask;
        int         wcyc;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    exp_t mon_e;

    int   checks        = 0;
    int   failures      = 0;
    int   cyc           = 0;
    int   write_total   = 0;
    int   ack_total     = 0;
    int   timeout_total = 0;
    int   poll_total    = 0;
    int   full_left     = 0;
    int   ack_cyc_exp   = 0;
    bit   ack_pending   = 1'b0;
    logic [3:0] ack_mask_exp = 4'b0;
    logic [3:0] last_timeout = 4'b0;

    rs232_tx_arbiter #(
        .DEVADDR       (DEV),
        .TIMEOUT_POLLS (TO_POLLS)
    ) dut (
        .cpu_clk     (cpu_clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .timeout_err (timeout_err),
        .outbus_addr (outbus_addr),
        .outbus_data (outbus_data),
        .outbus_we   (outbus_we),
        .inbus_addr  (inbus_addr),
        .inbus_re    (inbus_re),
        .inbus_data  (inbus_data)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Cycle counter used for latency checks.
    always @(posedge cpu_clk) cyc <= cyc + 1;

    // Port model: each status read returns full while full_left is nonzero.
    // Not-full is every bit except bit 1, so only the full flag may matter.
    always @(posedge cpu_clk) begin
        if (inbus_re) begin
            poll_total = poll_total + 1;
            if (full_left > 0) begin
                full_left = full_left - 1;
                inbus_data <= 8'h02;
            end else begin
                inbus_data <= 8'hFD;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Monitor: every write pops the scoreboard, every ack must follow its write.
    always @(negedge cpu_clk) begin
        if (!reset) begin
            if (inbus_re) checkOutput("status_addr", 32'(inbus_addr), 32'(DEV + 8'd1));
            if (outbus_we) begin
                write_total++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_write: got data %0h, required no write", outbus_data);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("write_data", 32'(outbus_data), 32'(mon_e.data));
                    checkOutput("write_addr", 32'(outbus_addr), 32'(DEV));
                    if (mon_e.wcyc >= 0) checkOutput("write_cycle", cyc, mon_e.wcyc);
                    ack_mask_exp = mon_e.mask;
                    ack_cyc_exp  = cyc + 1;
                    ack_pending  = 1'b1;
                end
            end
            if (ack != 4'b0) begin
                ack_total++;
                if (!ack_pending) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_ack: got %0h, required no ack", ack);
                end else begin
                    checkOutput("ack_mask", 32'(ack), 32'(ack_mask_exp));
                    checkOutput("ack_cycle", cyc, ack_cyc_exp);
                    ack_pending = 1'b0;
                end
            end
            if (timeout_err != 4'b0) begin
                timeout_total++;
                last_timeout = timeout_err;
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) @(negedge cpu_clk);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input int polls,
                                 input logic [7:0] eb, input logic [3:0] ea);
        exp_t e;
        @(negedge cpu_clk);
        req_data  = d;
        full_left = polls;
        // req seen at the next edge N; WRITE is the cycle after edge N+2,
        // and each extra full poll adds a STAT_RD/STAT_CHK round trip.
        e.data = eb;
        e.mask = ea;
        e.wcyc = cyc + 3 + 2 * polls;
        sb.push_back(e);
        req = r;
    endtask

    task automatic waitAcks(input int target, input int budget);
        int n = 0;
        while (ack_total < target && n < budget) begin
            @(negedge cpu_clk);
            #1;
            n++;
        end
        checkOutput("ack_wait", ack_total, target);
    endtask

    task automatic waitStatRead(input int budget);
        bit found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge cpu_clk);
            #1;
            if (inbus_re) found = 1'b1;
        end
        checkOutput("stat_rd_wait", 32'(found), 32'd1);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_we"}, 32'(outbus_we), 32'd0);
        checkOutput({tag, "_re"}, 32'(inbus_re), 32'd0);
        checkOutput({tag, "_oaddr"}, 32'(outbus_addr), 32'd0);
        checkOutput({tag, "_odata"}, 32'(outbus_data), 32'd0);
        checkOutput({tag, "_iaddr"}, 32'(inbus_addr), 32'd0);
        checkOutput({tag, "_ack"}, 32'(ack), 32'd0);
        checkOutput({tag, "_terr"}, 32'(timeout_err), 32'd0);
    endtask

    // Start a stuck-full transfer and hit reset in STAT_CHK (in_chk=1) or STAT_RD.
    task automatic resetMidTransfer(input bit in_chk);
        int bw, ba;
        idleCycles(4);
        @(negedge cpu_clk);
        req_data  = 32'h0000_00E1;
        full_left = 1000;
        req       = 4'b0001;
        waitStatRead(20);
        if (in_chk) @(negedge cpu_clk);
        bw    = write_total;
        ba    = ack_total;
        reset = 1'b1;
        #1;
        checkIdle(in_chk ? "rst_chk" : "rst_rd");
        req       = 4'b0;
        full_left = 0;
        idleCycles(3);
        reset = 1'b0;
        idleCycles(6);
        checkOutput("rst_no_write", write_total, bw);
        checkOutput("rst_no_ack", ack_total, ba);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: run still active at 400000, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_p, base_a, bw, c;
        logic [7:0] bytes4[4];

        // rr_ptr starts at 0; each row notes where it lands afterwards.
        vecs[0] = '{4'b0001, 32'h0000_0041, 0,        4'b0001, 8'h41}; // rr->1
        vecs[1] = '{4'b0100, 32'h005A_0000, 0,        4'b0100, 8'h5A}; // rr->3
        vecs[2] = '{4'b0011, 32'h0000_2110, 0,        4'b0001, 8'h10}; // 3 empty, 0 wins, rr->1
        vecs[3] = '{4'b0011, 32'h0000_2110, 0,        4'b0010, 8'h21}; // rr->2
        vecs[4] = '{4'b1001, 32'hB300_00A0, V4_POLLS, 4'b1000, 8'hB3}; // rr->0
        vecs[5] = '{4'b1000, 32'hFF00_0000, 0,        4'b1000, 8'hFF}; // wrap, rr->0

        reset     = 1'b1;
        req       = 4'b0;
        req_data  = 32'h0;
        full_left = 0;
        idleCycles(3);
        #1;
        checkIdle("reset");
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            idleCycles(4);
            base_p = poll_total;
            base_a = ack_total;
            applyStimulus(vecs[v].req, vecs[v].data, vecs[v].polls,
                          vecs[v].exp_byte, vecs[v].exp_ack);
            waitAcks(base_a + 1, 200);
            req = 4'b0;
            checkOutput("poll_count", poll_total - base_p, vecs[v].polls + 1);
        end

        // All four held: two full rounds from requester 0, writes 7 cycles apart.
        idleCycles(4);
        bytes4[0] = 8'h11;
        bytes4[1] = 8'h22;
        bytes4[2] = 8'h33;
        bytes4[3] = 8'h44;
        @(negedge cpu_clk);
        c         = cyc;
        req_data  = 32'h4433_2211;
        full_left = 0;
        base_a    = ack_total;
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.data = bytes4[k % 4];
            e.mask = 4'b0001 << (k % 4);
            e.wcyc = c + 3 + 7 * k;
            sb.push_back(e);
        end
        req = 4'b1111;
        waitAcks(base_a + 8, 300);
        req = 4'b0;

        // Withdrawal in STAT_CHK while full: no write, no ack, rr stays 0.
        idleCycles(4);
        @(negedge cpu_clk);
        req_data  = 32'h0077_0000;
        full_left = 1000;
        req       = 4'b0100;
        bw        = write_total;
        base_a    = ack_total;
        for (int p = 0; p < WD_POLLS; p++) waitStatRead(20);
        @(negedge cpu_clk);
        req       = 4'b0;
        full_left = 0;
        idleCycles(8);
        checkOutput("wd_no_write", write_total, bw);
        checkOutput("wd_no_ack", ack_total, base_a);
        // rr still 0 -> requester 2 wins over 3.
        idleCycles(2);
        base_a = ack_total;
        applyStimulus(4'b1100, 32'hD3C2_0000, 0, 8'hC2, 4'b0100);
        waitAcks(base_a + 1, 200);
        req = 4'b0;

        // rr is now 3; reset must return it to 0.
        resetMidTransfer(1'b1);
        base_a = ack_total;
        applyStimulus(4'b1100, 32'h6655_0000, 0, 8'h55, 4'b0100);
        waitAcks(base_a + 1, 200);
        req = 4'b0;

        resetMidTransfer(1'b0);

`ifdef RS232_ARB_TIMEOUT_EN
        // Requester 0 stuck behind a full FIFO for 3 polls is aborted;
        // requester 1 is served next.
        idleCycles(4);
        base_a = ack_total;
        begin
            exp_t e;
            int   base_t;
            int   n;
            @(negedge cpu_clk);
            req_data  = 32'h0000_2B1B;
            full_left = 3;
            e.data    = 8'h2B;
            e.mask    = 4'b0010;
            e.wcyc    = -1;
            sb.push_back(e);
            base_t = timeout_total;
            req    = 4'b0011;
            n      = 0;
            while (timeout_total == base_t && n < 100) begin
                @(negedge cpu_clk);
                #1;
                n++;
            end
            checkOutput("timeout_mask", 32'(last_timeout), 32'h1);
        end
        waitAcks(base_a + 1, 200);
        req = 4'b0;
`else
        // Reset left rr at 0: requester 0 wins over 1.
        idleCycles(4);
        base_a = ack_total;
        applyStimulus(4'b0011, 32'h0000_2A1A, 0, 8'h1A, 4'b0001);
        waitAcks(base_a + 1, 200);
        req = 4'b0;
`endif

        idleCycles(10);
        checkOutput("sb_empty", sb.size(), 0);
        checkOutput("ack_pending_end", 32'(ack_pending), 32'd0);
        checkOutput("timeout_count", timeout_total, EXP_TIMEOUTS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs232_tx_arbiter.md
RS232_TX_ARBITER -- requirements
Module: rs232_tx_arbiter

Interface
REQ-001 Parameter DEVADDR, default 8'h00: base address of the serial port being driven. Its write-data port is DEVADDR+0 and its write-status port is DEVADDR+1.
REQ-002 Parameter TIMEOUT_POLLS, default 8'd255: number of consecutive full-status polls before an abort (used only with RS232_ARB_TIMEOUT_EN).
REQ-003 cpu_clk  input  1  the block's only clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  per-requester transmit request; level signal, held until ack or until the requester withdraws it.
REQ-006 req_data  input  32  byte for requester i on bits [8i+7:8i]; held stable while req[i]=1.
REQ-007 ack  output  4  one-cycle pulse when requester i's byte has been written to the port.
REQ-008 timeout_err  output  4  one-cycle pulse when requester i's request is aborted by timeout.
REQ-009 outbus_addr  output  8 / outbus_data  output  8 / outbus_we  output  1: write bus to the port.
REQ-010 inbus_addr  output  8 / inbus_re  output  1 / inbus_data  input  8: read bus; read data is valid one cycle after inbus_re.

Function
REQ-011 States: IDLE, STAT_RD, STAT_CHK, WRITE, ACK, GAP; encoding is one-hot.
REQ-012 IDLE: if any req bit is set, select winner = first set bit scanning from rr_ptr upward mod 4, latch its index and byte, then go to STAT_RD.
REQ-013 STAT_RD: drive inbus_re=1 and inbus_addr=DEVADDR+1 for exactly one cycle, then go to STAT_CHK.
REQ-014 STAT_CHK: sample inbus_data[1] (tx-FIFO full). If 1, return to STAT_RD (re-poll). If 0, go to WRITE.
REQ-015 WRITE: drive outbus_we=1, outbus_addr=DEVADDR, outbus_data=latched byte for exactly one cycle, then go to ACK.
REQ-016 ACK: pulse ack[winner] for one cycle, set rr_ptr=(winner+1) mod 4, then go to GAP.
REQ-017 GAP: hold for 2 cycles with no bus activity, then go to IDLE. This allows the port's full flag to settle before the next poll.
REQ-018 Latency, idle to ack with FIFO not full: req sampled at edge N; outbus_we high in cycle N+3; ack high in cycle N+4.
REQ-019 Withdrawal: if req[winner] falls while in STAT_RD or STAT_CHK, go to IDLE with no write and no ack; rr_ptr is unchanged.
REQ-020 Once WRITE is entered the transfer completes: ack is issued even if req falls.
REQ-021 When not in the states above, outbus_we=0, inbus_re=0, and the address/data outputs are 0.
REQ-022 Simultaneous requests from all four requesters are served in order rr_ptr, rr_ptr+1, ... with no starvation; at most one transfer is in flight at a time.
REQ-023 A requester whose req is still high after ack is treated as a new request.

Reset
REQ-024 On reset: state=IDLE, rr_ptr=0, ack=0, timeout_err=0, outbus_we=0, inbus_re=0, all address/data outputs 0, poll counter=0.
REQ-025 Reset asserted mid-transfer aborts the transfer immediately; no ack is issued and no partial write occurs after reset.

Configuration
REQ-026 Macro RS232_ARB_TIMEOUT_EN defined: an 8-bit poll counter increments on each full result in STAT_CHK and clears on leaving STAT_CHK toward WRITE or IDLE. When the count reaches TIMEOUT_POLLS: pulse timeout_err[winner], advance rr_ptr, go to GAP, and issue no write.
REQ-027 Macro undefined: the counter is absent, timeout_err is tied to 4'b0, and polling continues indefinitely.

Verification
REQ-028 Single request: req=4'b0001, byte 8'h41, status 8'h00 -> one write of 8'h41 to DEVADDR at N+3; ack=4'b0001 at N+4.
REQ-029 All requests at once: req=4'b1111 held, bytes 11/22/33/44 -> writes in order 11,22,33,44, each followed by a 2-cycle gap; second round restarts at requester 0.
REQ-030 FIFO full: status 8'h02 for 5 polls, then 8'h00 -> 5 re-polls, exactly one write, one ack.
REQ-031 Withdrawal: req[2] dropped during STAT_CHK with status 8'h02 -> no write, no ack, rr_ptr unchanged.
REQ-032 Reset: reset asserted during STAT_CHK -> all outputs 0 within the same cycle, state IDLE, rr_ptr=0.
REQ-033 With RS232_ARB_TIMEOUT_EN, TIMEOUT_POLLS=8'd3, status stuck at 8'h02 -> timeout_err[0] pulses after the 3rd poll, no write occurs, and the next requester is served.
